divider_arbiter: RTL

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

---
 rtl/divider_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : divider_arbiter
// Description : Round-robin arbiter sharing one sequential divider among
//               N_REQ requesters, with a completion timeout. Define macro
//               DIV_ZERO_BYPASS_EN to answer divide-by-zero locally.
// Revision    : 1.0
// ============================================================================
module divider_arbiter #(
  parameter int N_REQ       = 4,
  parameter int W           = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] dividend_in,
  input  logic [N_REQ*W-1:0] divisor_in,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       quotient_out,
  output logic [W-1:0]       remainder_out,
  output logic               err,
  output logic               busy,
  output logic               div_start,
  output logic [W-1:0]       div_dividend,
  output logic [W-1:0]       div_divisor,
  input  logic               div_ready,
  input  logic [W-1:0]       div_quotient,
  input  logic [W-1:0]       div_remainder
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESPOND   = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] grant;
  logic [IW-1:0] prio;
  logic [IW-1:0] winner;
  logic [IW-1:0] next_prio;
  logic          found;
  logic          hi_found;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic [CW-1:0] tcnt;
  logic          timeout_hit;
  logic          zero_bypass;

  logic [W-1:0]  dvd_arr [N_REQ];
  logic [W-1:0]  dvs_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign dvd_arr[g] = dividend_in[g*W +: W];
    assign dvs_arr[g] = divisor_in[g*W +: W];
  end

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    found    = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if ((req & (N_REQ'(1) << i)) != '0) begin
        found  = 1'b1;
        lo_idx = IW'(i);
        if (i >= int'(prio)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    winner    = hi_found ? hi_idx : lo_idx;
    next_prio = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
  end

`ifdef DIV_ZERO_BYPASS_EN
  assign zero_bypass = (div_divisor == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  assign timeout_hit = (tcnt == CW'(TIMEOUT_CYC - 1));
  assign busy        = (state != S_IDLE);
  assign div_start   = (state == S_ISSUE) && !zero_bypass;
  assign ack         = (state == S_ISSUE)   ? (N_REQ'(1) << grant) : '0;
  assign done        = (state == S_RESPOND) ? (N_REQ'(1) << grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      grant         <= '0;
      prio          <= '0;
      tcnt          <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      quotient_out  <= '0;
      remainder_out <= '0;
      err           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found && div_ready) begin
            grant        <= winner;
            prio         <= next_prio;
            div_dividend <= dvd_arr[winner];
            div_divisor  <= dvs_arr[winner];
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt <= '0;
          if (zero_bypass) begin
            quotient_out  <= '1;
            remainder_out <= div_dividend;
            err           <= 1'b1;
            state         <= S_RESPOND;
          end else begin
            state <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (timeout_hit) begin
            quotient_out  <= '0;
            remainder_out <= '0;
            err           <= 1'b1;
            state         <= S_RESPOND;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (!div_ready) begin
              state <= S_WAIT_DONE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (div_ready) begin
            quotient_out  <= div_quotient;
            remainder_out <= div_remainder;
            err           <= 1'b0;
            state         <= S_RESPOND;
          end else if (timeout_hit) begin
            quotient_out  <= '0;
            remainder_out <= '0;
            err           <= 1'b1;
            state         <= S_RESPOND;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESPOND: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
